// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into program memory as 16-bit words, high byte first.
// Length 0 completes immediately; a length beyond the memory size is rejected.
module program_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state;
  logic [7:0]          len_hi;
  logic [7:0]          data_hi;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         len_full;
  logic                len_too_big;
  logic                last_word;

  assign len_full    = {len_hi, rx_data};
  assign len_too_big = ({16'd0, len_full} > (32'd1 << ADDR_W));
  // Compared before the increment so the final write and DONE land on the same edge.
  assign last_word   = ((word_count + WC_ONE) == len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_hi     <= '0;
      data_hi    <= '0;
      len        <= '0;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LEN_HI;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            addr       <= '0;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len <= (ADDR_W+1)'(len_full);
            if (len_full == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (len_too_big) begin
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (rx_valid) begin
            data_hi <= rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (rx_valid) begin
            wr_en      <= 1'b1;
            wr_data    <= {data_hi, rx_data};
            wr_addr    <= addr;
            addr       <= addr + ADDR_ONE;
            word_count <= word_count + WC_ONE;
            if (last_word) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader, checked against a byte-stream reference model.
module tb_program_loader;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          wr_en, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   word_count;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } wr_t;

  wr_t cap[$];
  wr_t exp[$];
  logic        exp_done, exp_err;
  logic [AW:0] exp_wc;
  int checks = 0;
  int errors = 0;

  program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) cap.push_back({wr_addr, wr_data});

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b; @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive(input bq_t b, input int maxgap);
    foreach (b[i]) send(b[i], $urandom_range(0, maxgap));
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || error) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!(done || error)) begin
      errors++; $display("FAIL %s timeout: done=%b error=%b, required one set", name, done, error);
    end
    #1;
  endtask

  // Reference: what a whole session stream should produce, from the length rules alone.
  task automatic model(input bq_t b);
    int len;
    exp.delete(); exp_done = 0; exp_err = 0; exp_wc = '0;
    len = {b[0], b[1]};
    if (len == 0) exp_done = 1;
    else if (len > (1 << AW)) exp_err = 1;
    else begin
      for (int i = 0; i < len; i++) exp.push_back({AW'(i), b[2+2*i], b[3+2*i]});
      exp_done = 1; exp_wc = (AW+1)'(len);
    end
  endtask

  function automatic bq_t mk(input int len);
    bq_t q;
    q.push_back(8'(len >> 8)); q.push_back(8'(len));
    for (int i = 0; i < 2*len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic int first_diff();
    if (cap.size() != exp.size()) return (cap.size() < exp.size()) ? cap.size() : exp.size();
    foreach (cap[i]) if (cap[i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {busy, done, error}); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL reset word_count: got %0d want 0", word_count); end
    rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_directed();
    bq_t b = '{8'h00, 8'h04, 8'h18, 8'h04, 8'h08, 8'h01, 8'h18, 8'h02, 8'h10, 8'h01};
    cap.delete(); pulse_start();
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL directed busy/done after start: got %b want 10", {busy, done}); end
    drive(b, 0); wait_end("directed"); model(b);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL directed writes: got %0d writes, diff at %0d, want %0d", cap.size(), first_diff(), exp.size()); end
    checks++; if ({busy, done, error} !== 3'b010) begin errors++; $display("FAIL directed flags: got %b want 010", {busy, done, error}); end
    checks++; if (word_count !== 4) begin errors++; $display("FAIL directed word_count: got %0d want 4", word_count); end
  endtask

  task automatic test_zero_len();
    cap.delete(); pulse_start(); send(8'h00, 0); send(8'h00, 0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_len done next cycle: got %b want 1", done); end
    repeat (3) @(negedge clk); #1;
    checks++; if (cap.size() != 0) begin errors++; $display("FAIL zero_len writes: got %0d want 0", cap.size()); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL zero_len word_count: got %0d want 0", word_count); end
  endtask

  task automatic test_error_recover();
    bq_t b = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    cap.delete(); pulse_start(); send(8'h08, 0); send(8'h01, 0);
    repeat (3) @(negedge clk); #1;
    checks++; if ({busy, done, error} !== 3'b001) begin errors++; $display("FAIL error flags: got %b want 001", {busy, done, error}); end
    checks++; if (cap.size() != 0) begin errors++; $display("FAIL error writes: got %0d want 0", cap.size()); end
    pulse_start();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error cleared by start: got %b want 0", error); end
    drive(b, 1); wait_end("recover"); model(b);
    checks++; if (first_diff() != -1 || cap.size() != 1) begin errors++; $display("FAIL recover writes: got %0d writes, diff at %0d, want 1", cap.size(), first_diff()); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL recover flags: got %b want 10", {done, error}); end
  endtask

  task automatic test_gaps();
    for (int s = 0; s < 8; s++) begin
      bq_t b = mk(s < 3 ? 3 : $urandom_range(1, 9));
      cap.delete(); pulse_start(); drive(b, s < 3 ? 5 : 1); wait_end("gaps"); model(b);
      checks++; if (first_diff() != -1) begin errors++; $display("FAIL gaps[%0d] writes: got %0d writes, diff at %0d, want %0d", s, cap.size(), first_diff(), exp.size()); end
      checks++; if (word_count !== exp_wc || done !== exp_done) begin errors++; $display("FAIL gaps[%0d] status: got wc=%0d done=%b want wc=%0d done=%b", s, word_count, done, exp_wc, exp_done); end
    end
  endtask

  task automatic test_reset_mid();
    bq_t b = mk(4);
    bq_t r = mk(2);
    cap.delete(); pulse_start();
    for (int i = 0; i < 5; i++) send(b[i], 0);
    rst = 1'b1; @(negedge clk); #1;
    checks++; if ({wr_en, busy, done, error} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0 || word_count !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got en=%b addr=%h data=%h flags=%b wc=%0d want all 0", wr_en, wr_addr, wr_data, {busy, done, error}, word_count);
    end
    checks++; if (cap.size() != 1) begin errors++; $display("FAIL reset_mid partial writes: got %0d want 1", cap.size()); end
    rst = 1'b0; @(negedge clk);
    cap.delete(); pulse_start(); drive(r, 0); wait_end("reload"); model(r);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL reload writes: got %0d writes, diff at %0d, want %0d", cap.size(), first_diff(), exp.size()); end
  endtask

  task automatic test_start_ignore();
    bq_t b = mk(2);
    cap.delete(); pulse_start(); send(b[0], 0); send(b[1], 0);
    pulse_start();
    start = 1'b1; send(b[2], 0); start = 1'b0;
    for (int i = 3; i < 6; i++) send(b[i], 0);
    wait_end("start_ignore"); model(b);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL start_ignore writes: got %0d writes, diff at %0d, want %0d", cap.size(), first_diff(), exp.size()); end
    checks++; if (word_count !== 2) begin errors++; $display("FAIL start_ignore word_count: got %0d want 2", word_count); end
  endtask

  task automatic test_start_discard();
    bq_t b = '{8'h00, 8'h01, 8'h11, 8'h22};
    cap.delete();
    start = 1'b1; send(8'h05, 0); start = 1'b0;
    drive(b, 0); wait_end("start_discard"); model(b);
    checks++; if (first_diff() != -1 || cap.size() != 1) begin errors++; $display("FAIL start_discard writes: got %0d writes, diff at %0d, want 1", cap.size(), first_diff()); end
  endtask

  task automatic test_max_len();
    bq_t b = mk(1 << AW);
    cap.delete(); pulse_start(); drive(b, 0); wait_end("max_len"); model(b);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL max_len writes: got %0d writes, diff at %0d, want %0d", cap.size(), first_diff(), exp.size()); end
    checks++; if (word_count !== (1 << AW) || done !== 1'b1) begin errors++; $display("FAIL max_len status: got wc=%0d done=%b want wc=%0d done=1", word_count, done, 1 << AW); end
    checks++; if (cap.size() > 0 && cap[cap.size()-1].a !== AW'((1 << AW) - 1)) begin errors++; $display("FAIL max_len last addr: got %h want %h", cap[cap.size()-1].a, (1 << AW) - 1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_error_recover();
    test_gaps();
    test_reset_mid();
    test_start_ignore();
    test_start_discard();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: program-memory address width (2048 words).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: begin a load session; sampled in IDLE, DONE, ERROR.
REQ-005 SHALL have port rx_data, input, 8: incoming byte.
REQ-006 SHALL have port rx_valid, input, 1: rx_data valid this cycle; one byte per asserted cycle.
REQ-007 SHALL have port wr_en, output, 1: program-memory write strobe, one cycle per word.
REQ-008 SHALL have port wr_addr, output, ADDR_W: program-memory write address.
REQ-009 SHALL have port wr_data, output, 16: instruction word to write.
REQ-010 SHALL have port busy, output, 1: session in progress (LEN_HI..DATA_LO).
REQ-011 SHALL have port done, output, 1: session completed successfully; level.
REQ-012 SHALL have port error, output, 1: length rejected; level.
REQ-013 SHALL have port word_count, output, ADDR_W+1: words written in current or last session.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR.
REQ-015 SHALL move IDLE/DONE/ERROR -> LEN_HI on start=1; clear done, error, word_count, and the address counter.
REQ-016 SHALL ignore start while busy=1, and ignore rx_valid in IDLE/DONE/ERROR.
REQ-017 SHALL, on rx_valid, capture the 16-bit length high byte first (LEN_HI -> LEN_LO -> next).
REQ-018 SHALL, after LEN_LO, go to DONE if length=0, to ERROR if length > 2^ADDR_W, else to DATA_HI.
REQ-019 SHALL assemble each word high byte first: DATA_HI captures rx_data into [15:8], DATA_LO into [7:0].
REQ-020 SHALL, on the cycle after the DATA_LO byte is accepted, assert wr_en for exactly one cycle, with wr_data = assembled word and wr_addr = current address (first word at 0).
REQ-021 SHALL increment address and word_count by 1 in the cycle of each wr_en.
REQ-022 SHALL return DATA_LO -> DATA_HI when words remain, else -> DONE; the final wr_en and entry to DONE coincide.
REQ-023 SHALL accept a byte on back-to-back rx_valid cycles in every data/length state; no byte dropped.
REQ-024 SHALL hold wr_addr and wr_data stable when wr_en=0; wr_en never asserted outside a session.
REQ-025 SHALL assert busy=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO.
REQ-026 SHALL hold done=1 in DONE and error=1 in ERROR until the next start or reset.
REQ-027 SHALL let length = 2^ADDR_W write addresses 0..2^ADDR_W-1 with no wrap, word_count ending at 2^ADDR_W.
REQ-028 SHALL, for start coincident with rx_valid in DONE/ERROR, take start and discard the byte.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, enter IDLE irrespective of state, including mid-session.
REQ-030 SHALL reset wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, word_count=0, partial word and length cleared.
REQ-031 SHALL give rst priority over start and rx_valid in the same cycle.

Verification
REQ-032 SHALL check: start; bytes 00 04 18 04 08 01 18 02 10 01 -> wr_en at addr 0..3 with 0x1804, 0x0801, 0x1802, 0x1001; done=1; word_count=4.
REQ-033 SHALL check: start; length bytes 00 00 -> DONE next cycle, no wr_en, done=1, word_count=0.
REQ-034 SHALL check: start; length bytes 08 01 (2049) -> ERROR, error=1, no wr_en; new start then 00 01 AB CD -> addr 0 = 0xABCD, error=0, done=1.
REQ-035 SHALL check: length 3 with rx_valid gaps of 0..5 idle cycles between bytes -> identical writes to back-to-back delivery.
REQ-036 SHALL check: rst=1 after the high byte of word 2 of a 4-word load -> all outputs at reset values next cycle; later start reloads from addr 0.
REQ-037 SHALL check: start pulsed during DATA_HI -> ignored, session completes unaffected.
